// File: rtl/rv32m_div_sequencer.sv
// Issue/control stage in front of the RV32M radix-4 divider: resolves divide-by-zero,
// signed overflow and paired DIV/REM cache hits locally, otherwise sequences the divider.
module rv32m_div_sequencer #(
  parameter int NUM_BITS = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          op,
  input  logic [NUM_BITS-1:0] rs1,
  input  logic [NUM_BITS-1:0] rs2,
  input  logic                flush,
  output logic [NUM_BITS-1:0] result,
  output logic                result_valid,
  output logic                busy,
  output logic                div_start,
  output logic                div_is_signed,
  output logic [NUM_BITS-1:0] div_dividend,
  output logic [NUM_BITS-1:0] div_divisor,
  input  logic [NUM_BITS-1:0] div_quotient,
  input  logic [NUM_BITS-1:0] div_remainder,
  input  logic                div_finished
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [NUM_BITS-1:0] MOST_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

  state_t              state;
  logic [1:0]          op_q;
  logic [NUM_BITS-1:0] a_q;
  logic [NUM_BITS-1:0] b_q;

  logic                c_valid;
  logic                c_signed;
  logic [NUM_BITS-1:0] c_a;
  logic [NUM_BITS-1:0] c_b;
  logic [NUM_BITS-1:0] c_q;
  logic [NUM_BITS-1:0] c_r;

  logic                req_signed;
  logic                is_zero;
  logic                is_ovf;
  logic                is_hit;
  logic                is_fast;
  logic [NUM_BITS-1:0] fast_result;

  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign div_is_signed = ~op_q[0];
  assign div_dividend  = a_q;
  assign div_divisor   = b_q;

  // Classification uses the raw request so fast results can be registered in the accept cycle.
  assign req_signed = ~op[0];
  assign is_zero    = (rs2 == '0);
  assign is_ovf     = req_signed && (rs1 == MOST_NEG) && (rs2 == '1);
  assign is_hit     = c_valid && (rs1 == c_a) && (rs2 == c_b) && (req_signed == c_signed);
  assign is_fast    = is_zero || is_ovf || is_hit;

  always_comb begin
    fast_result = '0;
    if (is_zero)
      fast_result = op[1] ? rs1 : '1;
    else if (is_ovf)
      fast_result = op[1] ? '0 : rs1;
    else
      fast_result = op[1] ? c_r : c_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      div_start    <= 1'b0;
      c_valid      <= 1'b0;
      c_signed     <= 1'b0;
      c_a          <= '0;
      c_b          <= '0;
      c_q          <= '0;
      c_r          <= '0;
    end else begin
      div_start    <= 1'b0;
      result_valid <= 1'b0;
      if (flush) begin
        // Squash wins over everything, including a request arriving in IDLE.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              op_q <= op;
              a_q  <= rs1;
              b_q  <= rs2;
              if (is_fast) begin
                result       <= fast_result;
                result_valid <= 1'b1;
                state        <= DONE;
              end else begin
                div_start <= 1'b1;
                state     <= START;
              end
            end
          end
          // div_finished may still be high from the previous op here, so it is not looked at.
          START: state <= WAIT;
          WAIT: begin
            if (div_finished) begin
              result       <= op_q[1] ? div_remainder : div_quotient;
              result_valid <= 1'b1;
              c_valid      <= 1'b1;
              c_signed     <= ~op_q[0];
              c_a          <= a_q;
              c_b          <= b_q;
              c_q          <= div_quotient;
              c_r          <= div_remainder;
              state        <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32m_div_sequencer.sv
// Randomised and directed bench for rv32m_div_sequencer with a behavioural divider and
// a scoreboard/monitor pair checking result value and cycle of every result_valid.
module tb_rv32m_div_sequencer;

  localparam int N = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic         CLK = 1'b0;
  logic         RST;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   op;
  logic [N-1:0] rs1, rs2;
  logic         flush;
  logic [N-1:0] result;
  logic         result_valid, busy, div_start, div_is_signed;
  logic [N-1:0] div_dividend, div_divisor;
  logic [N-1:0] div_quotient, div_remainder;
  logic         div_finished;

  rv32m_div_sequencer #(.NUM_BITS(N)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .rs1(rs1), .rs2(rs2), .flush(flush), .result(result), .result_valid(result_valid),
    .busy(busy), .div_start(div_start), .div_is_signed(div_is_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_finished(div_finished)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics, returns {quotient, remainder}.
  function automatic logic [63:0] ref_qr(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic s;
    s = ~o[0];
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
    if (s) return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
    return {a / b, a % b};
  endfunction

  function automatic logic [31:0] ref_res(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic [63:0] qr;
    qr = ref_qr(o, a, b);
    return o[1] ? qr[31:0] : qr[63:32];
  endfunction

  // Reference model of the one-entry cache: last operands that went through the divider.
  bit          mc_valid = 0;
  bit          mc_s;
  logic [31:0] mc_a, mc_b;

  function automatic bit is_fast(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    bit s;
    s = ~o[0];
    if (b == 32'h0) return 1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return mc_valid && a == mc_a && b == mc_b && s == mc_s;
  endfunction

  // Behavioural divider: finishes lat+1 cycles after the start cycle, reading operands at the end.
  int lat = 17;
  int cnt = 0;
  always @(posedge CLK) begin
    if (RST) begin
      cnt          <= 0;
      div_finished <= 1'b0;
      div_quotient <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      cnt          <= lat;
      div_finished <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        div_finished <= 1'b1;
        {div_quotient, div_remainder} <= ref_qr({1'b0, ~div_is_signed}, div_dividend, div_divisor);
      end
    end
  end

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  int start_cnt  = 0;
  int last_start = -1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (div_start) begin
        start_cnt++;
        last_start = cyc;
      end
      if (result_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result_valid: got result %h at cycle %0d, expected no result", result, cyc);
        end else begin
          e_mon = sb.pop_front();
          check("result", result, e_mon.val);
          check("result_cycle", cyc, e_mon.cyc);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after acceptance.
  task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] exp_v,
                       bit push, bit hold, output int acc_c, output bit fast);
    int guard;
    guard = 0;
    op = o; rs1 = a; rs2 = b; req_valid = 1'b1;
    while (!req_ready && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
    end
    acc_c = cyc;
    fast  = is_fast(o, a, b);
    if (push) sb.push_back('{exp_v, fast ? acc_c + 1 : acc_c + lat + 3});
    @(negedge CLK);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge CLK);
      g++;
    end while ((sb.size() != 0 || busy) && g < 200);
    if (g >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL completion_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    end
  endtask

  task automatic run_op(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] exp_v);
    int  acc_c, s0;
    bit  fast;
    s0 = start_cnt;
    issue(o, a, b, exp_v, 1, 0, acc_c, fast);
    wait_idle();
    check("start_count", start_cnt - s0, fast ? 0 : 1);
    if (!fast) begin
      check("start_cycle", last_start, acc_c + 1);
      mc_valid = 1; mc_a = a; mc_b = b; mc_s = ~o[0];
    end
    $display("op=%0d rs1=%h rs2=%h expect=%h fast=%0b lat=%0d accept_cycle=%0d",
             o, a, b, exp_v, fast, lat, acc_c);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc1, acc2, s0;
    bit          f1, f2;
    logic [1:0]  ro;
    logic [31:0] ra, rb, la, lb;

    RST = 1'b1; req_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_result", result, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_div_start", div_start, 0);
    check("reset_dividend", div_dividend, 0);
    check("reset_divisor", div_divisor, 0);
    check("reset_req_ready", req_ready, 1);
    RST = 1'b0;
    @(negedge CLK);

    lat = 17;
    run_op(OP_DIVU, 100, 7, 14);
    run_op(OP_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
    run_op(OP_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
    run_op(OP_DIV, 5, 0, 32'hFFFF_FFFF);
    run_op(OP_REMU, 5, 0, 5);
    run_op(OP_DIVU, 0, 0, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV, 100, 7, 14);
    run_op(OP_REM, 100, 7, 2);
    run_op(OP_REMU, 100, 7, 2);

    // Flush in the middle of a divide: no result, cache untouched.
    issue(OP_DIV, 1000, 3, 0, 0, 0, acc1, f1);
    while (cyc < acc1 + 10) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_result_valid", result_valid, 0);
    $display("op=%0d rs1=%h rs2=%h flushed at cycle %0d", OP_DIV, 32'd1000, 32'd3, acc1 + 10);
    run_op(OP_REM, 1000, 3, 1);

    // Reset during WAIT clears outputs and invalidates the cache.
    issue(OP_DIVU, 50, 9, 0, 0, 0, acc1, f1);
    while (cyc < acc1 + 8) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_div_start", div_start, 0);
    check("rst_dividend", div_dividend, 0);
    check("rst_divisor", div_divisor, 0);
    RST = 1'b0;
    mc_valid = 0;
    $display("op=%0d rs1=%h rs2=%h reset at cycle %0d", OP_DIVU, 32'd50, 32'd9, acc1 + 8);
    @(negedge CLK);
    run_op(OP_REM, 1000, 3, 1);
    run_op(OP_DIVU, 50, 9, 5);

    // Back-to-back: req_valid held across two requests.
    s0 = start_cnt;
    issue(OP_DIV, 5, 0, 32'hFFFF_FFFF, 1, 1, acc1, f1);
    issue(OP_DIVU, 9, 4, 2, 1, 0, acc2, f2);
    wait_idle();
    check("b2b_accept_cycle", acc2, acc1 + 2);
    check("b2b_start_count", start_cnt - s0, 1);
    mc_valid = 1; mc_a = 9; mc_b = 4; mc_s = 0;
    $display("back-to-back accepts at cycles %0d and %0d", acc1, acc2);

    la = 100; lb = 7;
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 20);
      ro  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin ra = $urandom; rb = 0; end
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3: begin ra = la; rb = lb; end
        4: begin ra = $urandom_range(0, 500); rb = $urandom_range(1, 20); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op(ro, ra, rb, ref_res(ro, ra, rb));
      if (rb != 0) begin la = ra; lb = rb; end
    end

    repeat (3) @(negedge CLK);
    check("final_queue_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
